// File: rtl/mont_pkg.sv
// Shared constants, coefficient type and stage-enable helper for the Montgomery pipeline.
// MONT_CANON_EN selects the four-stage canonicalising build.
package mont_pkg;

  localparam int COEFF_W = 16;
  localparam int KYBER_Q = 3329;
  localparam int QINV    = -3327;
  localparam int MONT    = -1044;

  typedef logic signed [COEFF_W-1:0] coeff_t;

`ifdef MONT_CANON_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  // Stage k may load when any slot from k to the output is free or the output drains.
  function automatic logic [STAGES-1:0] stage_enables(input logic [STAGES-1:0] v,
                                                      input logic out_ready);
    logic [STAGES-1:0] mask;
    logic [STAGES-1:0] en;
    en = '0;
    for (int k = 0; k < STAGES; k++) begin
      mask = '0;
      for (int j = 0; j < k; j++) mask[j] = 1'b1;
      en[k] = out_ready | ~&(v | mask);
    end
    return en;
  endfunction

endpackage

// File: rtl/mont_lane.sv
// One lane of the signed Montgomery reduction datapath (S1..S3, plus S4 under MONT_CANON_EN).
// Stage loads are driven by the shared enable vector from the top-level handshake.
module mont_lane #(
  parameter int W    = 16,
  parameter int Q    = mont_pkg::KYBER_Q,
  parameter int QINV = mont_pkg::QINV
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [mont_pkg::STAGES-1:0]   en_i,
  input  logic [2*W-1:0]                a_i,
  output logic [W-1:0]                  r_o
);
  import mont_pkg::*;

  localparam logic [W-1:0]   QINV_W = W'(QINV);
  localparam logic [2*W-1:0] Q_2W   = (2*W)'(Q);

  logic [2*W-1:0] a1_q, a2_q, p2_q, p2_d;
  logic [W-1:0]   t1_q, t1_d, r3_q, r3_d;

  // Only the low W bits of a*QINV are needed, so a W-bit multiply suffices.
  assign t1_d = a_i[W-1:0] * QINV_W;
  assign p2_d = {{W{t1_q[W-1]}}, t1_q} * Q_2W;
  assign r3_d = W'(($signed(a2_q) - $signed(p2_q)) >>> W);

`ifdef MONT_CANON_EN
  localparam logic [W-1:0] Q_W = W'(Q);
  logic [W-1:0] r4_q, r4_d;

  assign r4_d = r3_q[W-1] ? r3_q + Q_W : r3_q;
  assign r_o  = r4_q;
`else
  assign r_o  = r3_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q <= '0;
      t1_q <= '0;
      a2_q <= '0;
      p2_q <= '0;
      r3_q <= '0;
`ifdef MONT_CANON_EN
      r4_q <= '0;
`endif
    end else begin
      if (en_i[0]) begin
        a1_q <= a_i;
        t1_q <= t1_d;
      end
      if (en_i[1]) begin
        a2_q <= a1_q;
        p2_q <= p2_d;
      end
      if (en_i[2]) r3_q <= r3_d;
`ifdef MONT_CANON_EN
      if (en_i[3]) r4_q <= r4_d;
`endif
    end
  end

endmodule

// File: rtl/mont_reduce_pipe.sv
// Multi-lane stallable Montgomery reduction pipeline with valid/ready and a pass-through tag.
// Define MONT_CANON_EN to add the canonicalising stage (output in [0, Q), latency 4).
module mont_reduce_pipe #(
  parameter int W     = 16,
  parameter int Q     = mont_pkg::KYBER_Q,
  parameter int QINV  = mont_pkg::QINV,
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*2*W-1:0]   in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*W-1:0]     out_data,
  output logic [TAG_W-1:0]       out_tag
);
  import mont_pkg::*;

  logic [STAGES-1:0] v_q, v_d, en;
  logic [TAG_W-1:0]  tag_q [STAGES];

  always_comb begin
    en     = stage_enables(v_q, out_ready);
    v_d    = v_q;
    v_d[0] = en[0] ? in_valid : v_q[0];
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = en[k] ? v_q[k-1] : v_q[k];
    end
  end

  // Tags shadow the lane data registers so they stay in lockstep under stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      v_q <= v_d;
      if (en[0]) tag_q[0] <= in_tag;
      for (int k = 1; k < STAGES; k++) begin
        if (en[k]) tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mont_lane #(
      .W    (W),
      .Q    (Q),
      .QINV (QINV)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .a_i  (in_data[2*W*g +: 2*W]),
      .r_o  (out_data[W*g +: W])
    );
  end

endmodule
